apb_mem_slave: RTL and testbench
================================

// Module: apb_mem_slave
// PURPOSE
//  APB completer sitting directly downstream of the bridge's APB requester stage; consumes sel/enable/write/
//  strb/addr/wdata and returns ready/rdata/slverr. Word-organised byte-strobed memory of DEPTH words,
//  optional programmable wait-state generator, error response on out-of-range access. One per slave slot.
// PARAMETERS
//  ADDR_W   32   width of addr (already base-relative, word index in addr[ADDR_W-1:0])
//  DATA_W   32   data width; STRB_W = DATA_W/8 byte lanes
//  DEPTH    256  memory words; valid index range 0..DEPTH-1
//  WAIT_W   3    width of wait_cfg / internal wait counter
// PORTS
//  clk      in   1        clock, all state on rising edge
//  rst_n    in   1        asynchronous active-low reset
//  sel      in   1        slave select (PSEL)
//  enable   in   1        access phase (PENABLE)
//  write    in   1        1 = write, 0 = read
//  strb     in   STRB_W   byte-lane write enables, lane i = wdata[8i+7:8i]
//  addr     in   ADDR_W   word index
//  wdata    in   DATA_W   write data, lane-aligned by requester
//  wait_cfg in   WAIT_W   wait states per access (present only with APB_SLV_WAIT_EN)
//  ready    out  1        transfer completes this cycle (PREADY)
//  rdata    out  DATA_W   read data, valid only while ready=1 and write=0, else 0
//  slverr   out  1        error response, valid only while ready=1, else 0
// BEHAVIOUR
//  Reset: state=IDLE, wcnt=0, ready=0, rdata=0, slverr=0; memory contents NOT reset (X until written).
//  FSM states IDLE, ACCESS.
//   IDLE: on sel=1 & enable=0 (setup cycle) latch addr, write, and range flag oor=(addr>=DEPTH);
//     load wcnt=wait_cfg; latch rd_q=mem[addr] (0 if oor). Next state ACCESS. Otherwise stay IDLE.
//   ACCESS: ready=(wcnt==0) combinationally from registered state; while wcnt!=0 decrement by 1 per cycle.
//     Completion edge (sel&enable&ready): write & !oor -> mem[idx] lanes with strb[i]=1 updated, others kept;
//     next state IDLE. A new setup on the following cycle is accepted normally (back-to-back).
//     sel=0 while in ACCESS (requester timeout/abort): return to IDLE, no memory update, ready stays 0.
//  Latency: wait_cfg=N -> ready in access cycle N+1; N=0 gives zero-wait (2-cycle transfer).
//  rdata = rd_q when ready & !write & !oor, else 0. slverr = ready & oor (read or write).
//  strb=0 on write: completes normally with ready, no lanes change. strb ignored on reads.
//  wait_cfg sampled only in setup cycle; changes mid-access have no effect on that transfer.
//  Write then read of same word back-to-back returns new data (write commits before next setup latch).
//  sel=1 & enable=1 in IDLE (protocol violation): ignored, stay IDLE, ready=0.
//  rst_n low mid-access: immediate return to reset values; pending write discarded.
// CONFIGURATION
//  APB_SLV_WAIT_EN defined: wait_cfg port and wait counter present, behaviour as above.
//  APB_SLV_WAIT_EN undefined: no wait_cfg port, no counter; ready=1 in every ACCESS cycle (always zero-wait).
// TESTING
//  1 rst_n low then high, no traffic -> ready=0, rdata=0, slverr=0 every cycle.
//  2 wait_cfg=0: write addr=5 wdata=0xDEADBEEF strb=0xF, then read addr=5 -> ready in 1st access cycle,
//    rdata=0xDEADBEEF, slverr=0.
//  3 strb partial: write addr=5 wdata=0x00AA0000 strb=0x4 over 0xDEADBEEF -> read returns 0xDEAABEEF.
//  4 wait_cfg=2: read addr=5 -> ready low 2 access cycles, high on 3rd with rdata=0xDEAABEEF.
//  5 addr=DEPTH (256) write 0x12345678 then read -> both complete with slverr=1, read rdata=0,
//    and mem[0]/mem[255] unchanged.
//  6 wait_cfg=7 write addr=9, drop sel after 3 access cycles -> FSM IDLE, no ready, mem[9] unchanged;
//    also rst_n pulse mid-wait -> outputs 0 next cycle, subsequent write/read to addr 9 works.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB completer with a byte-strobed word memory, out-of-range error response and
// optional wait-state generator (enabled by defining APB_SLV_WAIT_EN).
module apb_mem_slave #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 256,
  parameter  int unsigned WAIT_W = 3,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              enable,
  input  logic              write,
  input  logic [STRB_W-1:0] strb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef APB_SLV_WAIT_EN
  input  logic [WAIT_W-1:0] wait_cfg,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              slverr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic                oor_q;
  logic [DATA_W-1:0]   rd_q;
  logic [WAIT_W-1:0]   wcnt;
  logic                setup;
  logic                addr_oor;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign addr_oor = (addr >= ADDR_W'(DEPTH));
  assign setup    = (state_q == IDLE) && sel && !enable;

  // ready is also qualified by sel so an aborted access never signals completion
  assign ready  = (state_q == ACCESS) && sel && (wcnt == '0);
  assign rdata  = (ready && !write_q && !oor_q) ? rd_q : '0;
  assign slverr = ready && oor_q;
  assign mem_we = ready && enable && write_q && !oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sel && !enable) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (enable && ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      oor_q   <= 1'b0;
      rd_q    <= '0;
    end else if (setup) begin
      idx_q   <= addr[IDX_W-1:0];
      write_q <= write;
      oor_q   <= addr_oor;
      rd_q    <= addr_oor ? '0 : mem[addr[IDX_W-1:0]];
    end
  end

`ifdef APB_SLV_WAIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (setup) begin
      wcnt <= wait_cfg;
    end else if ((state_q == ACCESS) && (wcnt != '0)) begin
      wcnt <= wcnt - 1'b1;
    end
  end
`else
  // No wait-state generator: a constant zero count makes every access cycle ready
  always_comb begin
    wcnt = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (strb[i]) begin
          mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized self-checking bench for apb_mem_slave against an array-based memory model;
// exercises wait states only when APB_SLV_WAIT_EN is defined.
module tb_apb_mem_slave;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned WAIT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        enable;
  logic        write;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef APB_SLV_WAIT_EN
  logic [2:0]  wait_cfg;
`endif
  logic        ready;
  logic [31:0] rdata;
  logic        slverr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  apb_mem_slave #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .WAIT_W(WAIT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .enable  (enable),
    .write   (write),
    .strb    (strb),
    .addr    (addr),
    .wdata   (wdata),
`ifdef APB_SLV_WAIT_EN
    .wait_cfg(wait_cfg),
`endif
    .ready   (ready),
    .rdata   (rdata),
    .slverr  (slverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
      sel    = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd0);
      check("idle_rdata", rdata, 32'd0);
      check("idle_slverr", 32'(slverr), 32'd0);
    end
  endtask

  // One APB transfer. ab / rs: access-cycle index at which sel is dropped or reset
  // is pulsed (-1 = never). Expected timing comes from the wait count alone.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int unsigned w, input int ab, input int rs);
    int unsigned weff;
    bit          oor;
    logic [31:0] exp_rd;
    logic [7:0]  ix;
`ifdef APB_SLV_WAIT_EN
    weff = w;
`else
    weff = 0;
`endif
    oor = (a >= DEPTH);
    ix  = a[7:0];
    @(posedge clk); #1;
    sel    = 1'b1;
    enable = 1'b0;
    write  = wr;
    addr   = a;
    wdata  = d;
    strb   = s;
`ifdef APB_SLV_WAIT_EN
    wait_cfg = w[2:0];
`endif
    @(negedge clk);
    check("setup_ready", 32'(ready), 32'd0);
    for (int c = 0; c <= int'(weff); c++) begin
      @(posedge clk); #1;
      enable = 1'b1;
`ifdef APB_SLV_WAIT_EN
      wait_cfg = 3'($urandom);
`endif
      if (c == rs) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_slverr", 32'(slverr), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        sel    = 1'b0;
        enable = 1'b0;
        return;
      end
      if (c == ab) begin
        sel    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle_ready", 32'(ready), 32'd0);
        return;
      end
      @(negedge clk);
      if (c < int'(weff)) begin
        check("wait_ready", 32'(ready), 32'd0);
        check("wait_slverr", 32'(slverr), 32'd0);
      end else begin
        exp_rd = (!wr && !oor) ? mdl[ix] : 32'd0;
        check("done_ready", 32'(ready), 32'd1);
        check(wr ? "wr_rdata" : "rd_rdata", rdata, exp_rd);
        check("done_slverr", 32'(slverr), 32'(oor));
        if (wr && !oor) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i]) mdl[ix][8*i +: 8] = d[8*i +: 8];
          end
        end
      end
    end
  endtask

  initial begin
    bit          wr;
    logic [31:0] a;
    int unsigned w;
    int          ab;
    int          rs;
    logic [31:0] save0;
    logic [31:0] save255;

    rst_n  = 1'b0;
    sel    = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
    strb   = '0;
    addr   = '0;
    wdata  = '0;
`ifdef APB_SLV_WAIT_EN
    wait_cfg = '0;
`endif
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_slverr", 32'(slverr), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      xfer(1'b1, 32'(i), $urandom, 4'hF, $urandom_range(0, 1), -1, -1);
    end

    // full write / read back, then partial lane write
    xfer(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, -1, -1);
    xfer(1'b0, 32'd5, 32'h0, 4'h0, 0, -1, -1);
    check("t2_model", mdl[5], 32'hDEADBEEF);
    xfer(1'b1, 32'd5, 32'h00AA0000, 4'h4, 0, -1, -1);
    xfer(1'b0, 32'd5, 32'h0, 4'hF, 0, -1, -1);
    check("t3_model", mdl[5], 32'hDEAABEEF);
    xfer(1'b0, 32'd5, 32'h0, 4'h0, 2, -1, -1);

    // out-of-range write and read, neighbours untouched
    save0   = mdl[0];
    save255 = mdl[255];
    xfer(1'b1, 32'd256, 32'h12345678, 4'hF, 0, -1, -1);
    xfer(1'b0, 32'd256, 32'h0, 4'h0, 1, -1, -1);
    xfer(1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 0, -1, -1);
    xfer(1'b0, 32'd0, 32'h0, 4'h0, 0, -1, -1);
    xfer(1'b0, 32'd255, 32'h0, 4'h0, 0, -1, -1);
    check("t5_mem0", mdl[0], save0);
    check("t5_mem255", mdl[255], save255);

    // abort and mid-access reset leave memory alone
    xfer(1'b1, 32'd9, 32'hCAFEF00D, 4'hF, 7, 3, -1);
    xfer(1'b1, 32'd9, 32'h0BADF00D, 4'hF, 7, 0, -1);
    xfer(1'b0, 32'd9, 32'h0, 4'h0, 0, -1, -1);
    xfer(1'b1, 32'd9, 32'h55AA55AA, 4'hF, 7, -1, 2);
    xfer(1'b1, 32'd9, 32'h11223344, 4'hF, 3, -1, 0);
    idle(1);
    xfer(1'b1, 32'd9, 32'h600DC0DE, 4'hF, 1, -1, -1);
    xfer(1'b0, 32'd9, 32'h0, 4'h0, 0, -1, -1);

    // strobe-free write completes without changing data
    xfer(1'b1, 32'd7, 32'hFFFF_FFFF, 4'h0, 0, -1, -1);
    xfer(1'b0, 32'd7, 32'h0, 4'h0, 0, -1, -1);

    // enable asserted without a setup cycle is ignored
    @(posedge clk); #1;
    sel    = 1'b1;
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'd7;
    wdata  = 32'hA5A5A5A5;
    strb   = 4'hF;
    repeat (2) begin
      @(negedge clk);
      check("viol_ready", 32'(ready), 32'd0);
    end
    xfer(1'b0, 32'd7, 32'h0, 4'h0, 0, -1, -1);

    repeat (400) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 15) == 0) ? 32'(DEPTH + $urandom_range(0, 1000))
                                         : 32'($urandom_range(0, DEPTH - 1));
      w  = $urandom_range(0, 7);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, w)) : -1;
      rs = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, w)) : -1;
      xfer(wr, a, $urandom, 4'($urandom), w, ab, rs);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
